// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous SRAM between the CPU bus
// (read/write) and the VDP pixel fetch (read-only). One access is in flight
// at a time, so the SRAM sees at most one access every two cycles. The VDP
// normally wins, but a pending CPU request forcibly wins once it has lost
// CPU_MAX_WAIT VDP grants in a row.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int CPU_MAX_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vdp_req,
    input  logic [ADDR_W-1:0] vdp_addr,
    output logic              vdp_ack,
    output logic [DATA_W-1:0] vdp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                WAIT_W     = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(CPU_MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_VDP  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        owner;
    logic              owner_we;
    logic [WAIT_W-1:0] wait_cnt;

    logic cpu_cand;
    logic vdp_cand;
    logic cpu_forced;
    logic grant_cpu;
    logic grant_vdp;
    logic grant_any;
    logic finishing_cpu;
    logic finishing_vdp;

    // Decide who may compete this cycle. In IDLE both requesters compete.
    // At the end of an access the owner's request is still high because it
    // has not seen its ack yet, so the owner is never re-granted on its own:
    // a CPU owner is excluded outright, and a VDP owner only stays in the
    // running while the CPU is also waiting, where the wait guard bounds how
    // long the VDP can keep the memory.
    always_comb begin
        cpu_cand = 1'b0;
        vdp_cand = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_cand = cpu_req;
                vdp_cand = vdp_req;
            end
            ST_DATA: begin
                if (owner == OWN_CPU) begin
                    vdp_cand = vdp_req;
                end else if (cpu_req) begin
                    cpu_cand = 1'b1;
                    vdp_cand = vdp_req;
                end
            end
            default: begin
                cpu_cand = 1'b0;
                vdp_cand = 1'b0;
            end
        endcase
    end

    // Fixed VDP priority, overridden once the CPU has lost enough grants.
    always_comb begin
        cpu_forced    = (wait_cnt == WAIT_LIMIT);
        grant_vdp     = vdp_cand && !(cpu_cand && cpu_forced);
        grant_cpu     = cpu_cand && !grant_vdp;
        grant_any     = grant_cpu || grant_vdp;
        finishing_cpu = (state == ST_DATA) && (owner == OWN_CPU);
        finishing_vdp = (state == ST_DATA) && (owner == OWN_VDP);
    end

    // Access sequencer: IDLE -> ADDR -> DATA, chaining straight back to ADDR
    // when a new winner exists at the end of an access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
        end else if (state == ST_ADDR) begin
            state <= ST_DATA;
        end else if (grant_any) begin
            state    <= ST_ADDR;
            owner    <= grant_cpu ? OWN_CPU : OWN_VDP;
            owner_we <= grant_cpu && cpu_we;
        end else begin
            state    <= ST_IDLE;
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
        end
    end

    // SRAM port registers: the winner's address and data are captured once at
    // grant, and the write strobe lasts exactly the one ADDR cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else if (grant_any) begin
            mem_addr  <= grant_cpu ? cpu_addr : vdp_addr;
            mem_wdata <= cpu_wdata;
            mem_we    <= grant_cpu && cpu_we;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Completion: one-cycle ack to the owner and read data capture; a CPU
    // write leaves the last CPU read data in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack   <= 1'b0;
            vdp_ack   <= 1'b0;
            cpu_rdata <= '0;
            vdp_rdata <= '0;
        end else begin
            cpu_ack <= finishing_cpu;
            vdp_ack <= finishing_vdp;
            if (finishing_cpu && !owner_we) begin
                cpu_rdata <= mem_rdata;
            end
            if (finishing_vdp) begin
                vdp_rdata <= mem_rdata;
            end
        end
    end

    // Count VDP grants lost by a pending CPU; saturates at the limit and
    // clears once the CPU is served or stops asking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!cpu_req || grant_cpu) begin
            wait_cnt <= '0;
        end else if (grant_vdp && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural
// synchronous SRAM. Each task drives one scenario and checks its own results.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vdp_req;
    logic [15:0] vdp_addr;
    logic        vdp_ack;
    logic [7:0]  vdp_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;
    int cpu_ack_cnt = 0;
    int vdp_ack_cnt = 0;
    int we_cnt      = 0;

    bit         wr_valid [0:65535];
    logic [7:0] wr_data  [0:65535];

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .CPU_MAX_WAIT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .vdp_req   (vdp_req),
        .vdp_addr  (vdp_addr),
        .vdp_ack   (vdp_ack),
        .vdp_rdata (vdp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Initial memory image for locations never written.
    function automatic logic [7:0] preload(input logic [15:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            16'h1234: v = 8'hA5;
            16'h0300: v = 8'h77;
            16'h0400: v = 8'h11;
            16'h0500: v = 8'h22;
            16'h0600: v = 8'h5A;
            default:  v = 8'h00;
        endcase
        if (a[15:4] == 12'h800) v = 8'h40 + {4'h0, a[3:0]};
        return v;
    endfunction

    // Synchronous SRAM: samples address/write at posedge, read data next cycle.
    always @(posedge clk) begin
        if (mem_we) begin
            wr_valid[mem_addr] <= 1'b1;
            wr_data[mem_addr]  <= mem_wdata;
        end
        mem_rdata <= wr_valid[mem_addr] ? wr_data[mem_addr] : preload(mem_addr);
    end

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (cpu_ack) cpu_ack_cnt++;
        if (vdp_ack) vdp_ack_cnt++;
        if (mem_we)  we_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] addr,
                              input logic [7:0] wd, output int lat);
        bit got;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = -1;
        got = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!got) begin
                tick();
                if (cpu_ack) begin
                    lat = i;
                    got = 1'b1;
                end
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vdp_req = 1'b0; vdp_addr = '0;
        repeat (3) @(negedge clk);
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_cpu_ack got=%0h exp=0", cpu_ack); end
        total++; if (vdp_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_vdp_ack got=%0h exp=0", vdp_ack); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we got=%0h exp=0", mem_we); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
        total++; if (mem_wdata !== 8'h0) begin bad++; $display("[TB] FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
        total++; if (cpu_rdata !== 8'h0) begin bad++; $display("[TB] FAIL reset_cpu_rdata got=%0h exp=0", cpu_rdata); end
        total++; if (vdp_rdata !== 8'h0) begin bad++; $display("[TB] FAIL reset_vdp_rdata got=%0h exp=0", vdp_rdata); end
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (3) tick();
        total++; if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset we=%0h ack=%0h exp=0", mem_we, cpu_ack); end
    endtask

    task automatic test_cpu_read();
        int we0;
        we0 = we_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        tick();
        total++; if (mem_addr !== 16'h1234) begin bad++; $display("[TB] FAIL rd_mem_addr got=%0h exp=1234", mem_addr); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rd_mem_we got=%0h exp=0", mem_we); end
        tick();
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("[TB] FAIL rd_early_ack got=%0h exp=0", cpu_ack); end
        tick();
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("[TB] FAIL rd_ack got=%0h exp=1", cpu_ack); end
        total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("[TB] FAIL rd_data got=%0h exp=a5", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("[TB] FAIL rd_ack_width got=%0h exp=0", cpu_ack); end
        tick();
        total++; if (we_cnt - we0 !== 0) begin bad++; $display("[TB] FAIL rd_we_pulses got=%0d exp=0", we_cnt - we0); end
    endtask

    task automatic test_cpu_write();
        int we0;
        int lat;
        we0 = we_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h3C;
        tick();
        total++; if (mem_we !== 1'b1) begin bad++; $display("[TB] FAIL wr_mem_we got=%0h exp=1", mem_we); end
        total++; if (mem_wdata !== 8'h3C) begin bad++; $display("[TB] FAIL wr_mem_wdata got=%0h exp=3c", mem_wdata); end
        total++; if (mem_addr !== 16'h0200) begin bad++; $display("[TB] FAIL wr_mem_addr got=%0h exp=200", mem_addr); end
        tick();
        total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL wr_we_drop got=%0h exp=0", mem_we); end
        tick();
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("[TB] FAIL wr_ack got=%0h exp=1", cpu_ack); end
        total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("[TB] FAIL wr_rdata_kept got=%0h exp=a5", cpu_rdata); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (2) tick();
        total++; if (we_cnt - we0 !== 1) begin bad++; $display("[TB] FAIL wr_we_pulses got=%0d exp=1", we_cnt - we0); end
        cpu_access(1'b0, 16'h0200, 8'h00, lat);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL wr_readback_lat got=%0d exp=3", lat); end
        total++; if (cpu_rdata !== 8'h3C) begin bad++; $display("[TB] FAIL wr_readback got=%0h exp=3c", cpu_rdata); end
    endtask

    task automatic test_vdp_stream();
        int a0;
        int gap;
        bit got;
        logic [7:0] exp;
        a0 = vdp_ack_cnt;
        vdp_req = 1'b1; vdp_addr = 16'h8000;
        for (int i = 0; i < 16; i++) begin
            gap = 0;
            got = 1'b0;
            while (!got && gap < 12) begin
                tick();
                gap++;
                if (vdp_ack) got = 1'b1;
            end
            exp = 8'(8'h40 + i);
            total++; if (!got || gap != 3) begin bad++; $display("[TB] FAIL vdp_gap[%0d] got=%0d exp=3", i, gap); end
            total++; if (vdp_rdata !== exp) begin bad++; $display("[TB] FAIL vdp_data[%0d] got=%0h exp=%0h", i, vdp_rdata, exp); end
            vdp_addr = 16'(32'h8000 + i + 1);
        end
        vdp_req = 1'b0;
        repeat (2) tick();
        total++; if (vdp_ack_cnt - a0 !== 16) begin bad++; $display("[TB] FAIL vdp_ack_count got=%0d exp=16", vdp_ack_cnt - a0); end
    endtask

    task automatic test_contention();
        logic [7:0] order [6];
        logic [7:0] exp;
        int n;
        int cyc;
        int last_c;
        int we0;
        n = 0; cyc = 0; last_c = -1;
        we0 = we_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
        vdp_req = 1'b1; vdp_addr = 16'h0500;
        while (n < 6 && cyc < 60) begin
            tick();
            cyc++;
            if (vdp_ack) begin
                order[n] = "V";
                n++;
                total++; if (vdp_rdata !== 8'h22) begin bad++; $display("[TB] FAIL cont_vdp_data got=%0h exp=22", vdp_rdata); end
            end else if (cpu_ack) begin
                order[n] = "C";
                n++;
                total++; if (cpu_rdata !== 8'h77) begin bad++; $display("[TB] FAIL cont_cpu_data got=%0h exp=77", cpu_rdata); end
                if (last_c >= 0) begin
                    total++; if (cyc - last_c > 7) begin bad++; $display("[TB] FAIL cont_cpu_gap got=%0d exp<=7", cyc - last_c); end
                end
                last_c = cyc;
            end
        end
        cpu_req = 1'b0; vdp_req = 1'b0;
        repeat (8) tick();
        total++; if (n != 6) begin bad++; $display("[TB] FAIL cont_ack_count got=%0d exp=6", n); end
        for (int k = 0; k < n; k++) begin
            exp = ((k % 3) == 2) ? "C" : "V";
            total++; if (order[k] !== exp) begin bad++; $display("[TB] FAIL cont_order[%0d] got=%c exp=%c", k, order[k], exp); end
        end
        total++; if (we_cnt - we0 !== 0) begin bad++; $display("[TB] FAIL cont_we_pulses got=%0d exp=0", we_cnt - we0); end
    endtask

    task automatic test_reset_mid_write();
        int c0;
        int lat;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0600; cpu_wdata = 8'h99;
        tick();
        total++; if (mem_we !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_we got=%0h exp=1", mem_we); end
        #2 reset = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_we got=%0h exp=0", mem_we); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("[TB] FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
        total++; if (mem_wdata !== 8'h0) begin bad++; $display("[TB] FAIL rst_mem_wdata got=%0h exp=0", mem_wdata); end
        total++; if (cpu_rdata !== 8'h0) begin bad++; $display("[TB] FAIL rst_cpu_rdata got=%0h exp=0", cpu_rdata); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        c0 = cpu_ack_cnt;
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (4) tick();
        total++; if (cpu_ack_cnt - c0 !== 0) begin bad++; $display("[TB] FAIL rst_no_ack got=%0d exp=0", cpu_ack_cnt - c0); end
        cpu_access(1'b0, 16'h0600, 8'h00, lat);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL rst_idle_lat got=%0d exp=3", lat); end
        total++; if (cpu_rdata !== 8'h5A) begin bad++; $display("[TB] FAIL rst_no_write got=%0h exp=5a", cpu_rdata); end
    endtask

    task automatic test_cpu_drop();
        int c0;
        int v0;
        bit saw;
        c0 = cpu_ack_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
        tick();
        cpu_req = 1'b0;
        repeat (6) tick();
        total++; if (cpu_ack_cnt - c0 !== 1) begin bad++; $display("[TB] FAIL drop_after_ack got=%0d exp=1", cpu_ack_cnt - c0); end
        total++; if (cpu_rdata !== 8'h11) begin bad++; $display("[TB] FAIL drop_after_data got=%0h exp=11", cpu_rdata); end
        c0 = cpu_ack_cnt;
        v0 = vdp_ack_cnt;
        saw = 1'b0;
        vdp_req = 1'b1; vdp_addr = 16'h0500;
        tick();
        cpu_req = 1'b1; cpu_addr = 16'h0700;
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vdp_ack) vdp_req = 1'b0;
            if (mem_addr === 16'h0700) saw = 1'b1;
        end
        total++; if (cpu_ack_cnt - c0 !== 0) begin bad++; $display("[TB] FAIL drop_before_ack got=%0d exp=0", cpu_ack_cnt - c0); end
        total++; if (saw !== 1'b0) begin bad++; $display("[TB] FAIL drop_before_access got=%0h exp=0", saw); end
        total++; if (vdp_ack_cnt - v0 !== 1) begin bad++; $display("[TB] FAIL drop_vdp_ack got=%0d exp=1", vdp_ack_cnt - v0); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_vdp_stream();
        test_contention();
        test_reset_mid_write();
        test_cpu_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
